nes_pad_reader: RTL and testbench
=================================

NES_PAD_READER -- requirements
Module: nes_pad_reader

Interface
REQ-001 Parameter LATCH_CYC, default 300: latch_out high time in clocks (12 us at 25 MHz); legal range >= 4.
REQ-002 Parameter HALF_CYC, default 150: clk_out half-period in clocks (6 us at 25 MHz); legal range >= 3.
REQ-003 clk_25mhz  input  1  system clock. The block has one clock only.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 poll  input  1  single-cycle request to read the pad (driven by the interrupt counter).
REQ-006 data_in  input  1  serial pad data, asynchronous, active-low (0 = pressed).
REQ-007 latch_out  output  1  pad latch strobe, registered.
REQ-008 clk_out  output  1  pad shift clock, registered, idles low.
REQ-009 controller_data  output  8  button state, 1 = pressed; bit order [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right.
REQ-010 pressed  output  8  buttons newly pressed since the previous completed read.
REQ-011 data_valid  output  1  one-cycle pulse when controller_data/pressed update.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 data_in SHALL pass through a 2-flop synchronizer; all sampling SHALL use the synchronized value.
REQ-014 FSM states SHALL be IDLE, LATCH, LOW, HIGH, DONE.
REQ-015 IDLE: latch_out=0, clk_out=0; poll=1 -> LATCH with phase counter=0 and bit index=0.
REQ-016 LATCH: latch_out=1 for exactly LATCH_CYC cycles, then -> LOW.
REQ-017 LOW: clk_out=0 for exactly HALF_CYC cycles; on its last cycle, ~sync_data SHALL be stored in shift bit [index]; if index=7 -> DONE, else index+1 and -> HIGH.
REQ-018 HIGH: clk_out=1 for exactly HALF_CYC cycles, then -> LOW.
REQ-019 A read SHALL produce exactly 7 clk_out pulses and 1 latch pulse; total busy time = LATCH_CYC + 8*HALF_CYC + 7*HALF_CYC + 1 cycles (DONE lasts 1 cycle).
REQ-020 DONE: controller_data <= shift; pressed <= shift & ~controller_data(old); data_valid=1 for this single cycle; -> IDLE.
REQ-021 controller_data and pressed SHALL hold their values between DONE cycles; pressed is not self-clearing.
REQ-022 poll asserted while busy=1 (including the DONE cycle) SHALL be ignored, not queued.
REQ-023 poll in the IDLE cycle immediately following DONE SHALL start a new read.
REQ-024 Phase counter SHALL be sized ceil(log2(max(LATCH_CYC,HALF_CYC)))+1 bits; no wrap-around within a phase.
REQ-025 latch_out and clk_out SHALL never be high in the same cycle.

Reset
REQ-026 rst low SHALL asynchronously force: state=IDLE, latch_out=0, clk_out=0, controller_data=0, pressed=0, data_valid=0, busy=0, counters=0, synchronizer flops=1 (idle, not pressed).
REQ-027 Reset asserted mid-read SHALL abort the read with no data_valid pulse and no update of controller_data; first poll after release starts a full read.
REQ-028 Reset release SHALL be honoured on the next clk_25mhz edge; poll on that edge is accepted.

Verification (LATCH_CYC=6, HALF_CYC=3; busy time = 6+24+21+1 = 52 cycles)
REQ-029 Pad model drives A and Start pressed (serial 0,1,1,0,1,1,1,1), poll pulse -> latch_out high 6 cycles, 7 clk_out pulses of 3 cycles, data_valid 52 cycles after poll, controller_data=8'h09, pressed=8'h09.
REQ-030 Second read with only Start and Right pressed -> controller_data=8'h88, pressed=8'h80.
REQ-031 poll re-pulsed at cycles 10 and 51 of a read -> no extra latch pulse, exactly one data_valid, busy low after 52 cycles.
REQ-032 rst low at cycle 30 of a read (prior controller_data=8'h09) -> outputs immediately at reset values; no data_valid; next read completes normally.
REQ-033 data_in held 1 (no pad) -> controller_data=8'h00, pressed=8'h00; data_in held 0 -> 8'hFF, pressed=8'hFF if previous was 8'h00.
REQ-034 Assertion throughout all tests: latch_out & clk_out never both 1; clk_out low whenever busy=0.

Source files
------------

// File: rtl/nes_pad_reader_if.sv
// Signal bundle between an NES pad reader and its host/pad side.
// The reader takes the slave view; the host and pad take the master view.
interface nes_pad_reader_if;
   logic       poll;
   logic       data_in;
   logic       latch_out;
   logic       clk_out;
   logic [7:0] controller_data;
   logic [7:0] pressed;
   logic       data_valid;
   logic       busy;

   modport master (
      output poll,
      output data_in,
      input  latch_out,
      input  clk_out,
      input  controller_data,
      input  pressed,
      input  data_valid,
      input  busy
   );

   modport slave (
      input  poll,
      input  data_in,
      output latch_out,
      output clk_out,
      output controller_data,
      output pressed,
      output data_valid,
      output busy
   );
endinterface

// File: rtl/nes_pad_reader.sv
// NES controller serial reader: latch strobe, 8 bit-times on the shift clock,
// then publishes the button byte plus a newly-pressed mask for one DONE cycle.
module nes_pad_reader #(
   parameter int LATCH_CYC = 300,
   parameter int HALF_CYC  = 150
) (
   input logic             clk_25mhz,
   input logic             rst,
   nes_pad_reader_if.slave pad
);
   localparam int MAX_CYC = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;
   localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYC - 1);
   localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYC - 1);

   typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [2:0]       idx_reg, idx_next;
   logic [7:0]       shift_reg, shift_next;
   logic [7:0]       data_reg, data_next;
   logic [7:0]       pressed_reg, pressed_next;
   logic             sync1_reg, sync2_reg;
   logic             latch_reg, clk_reg, valid_reg;
   logic             capture;
   logic             commit;

   // Synchronizer idles high so reset reads as "no button pressed".
   always_ff @(posedge clk_25mhz or negedge rst) begin
      if (!rst) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
      end else begin
         sync1_reg <= pad.data_in;
         sync2_reg <= sync1_reg;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pad.poll) begin
               state_next = LATCH;
               cnt_next   = '0;
               idx_next   = '0;
            end
         end
         LATCH: begin
            if (cnt_reg == LATCH_LAST) begin
               state_next = LOW;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         LOW: begin
            if (cnt_reg == HALF_LAST) begin
               capture  = 1'b1;
               cnt_next = '0;
               if (idx_reg == 3'd7) begin
                  state_next = DONE;
               end else begin
                  idx_next   = idx_reg + 3'd1;
                  state_next = HIGH;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         HIGH: begin
            if (cnt_reg == HALF_LAST) begin
               state_next = LOW;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Each bit samples the inverted pad line at the end of its own LOW phase.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_shift
         assign shift_next[gi] = (capture && (idx_reg == 3'(gi))) ? ~sync2_reg
                                                                  : shift_reg[gi];
      end
   endgenerate

   // Results are loaded on entry to DONE so they are already valid while data_valid is high.
   assign commit       = capture && (idx_reg == 3'd7);
   assign data_next    = commit ? shift_next : data_reg;
   assign pressed_next = commit ? (shift_next & ~data_reg) : pressed_reg;

   always_ff @(posedge clk_25mhz or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         idx_reg     <= '0;
         shift_reg   <= '0;
         data_reg    <= '0;
         pressed_reg <= '0;
         latch_reg   <= 1'b0;
         clk_reg     <= 1'b0;
         valid_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         idx_reg     <= idx_next;
         shift_reg   <= shift_next;
         data_reg    <= data_next;
         pressed_reg <= pressed_next;
         latch_reg   <= (state_next == LATCH);
         clk_reg     <= (state_next == HIGH);
         valid_reg   <= (state_next == DONE);
      end
   end

   assign pad.latch_out       = latch_reg;
   assign pad.clk_out         = clk_reg;
   assign pad.controller_data = data_reg;
   assign pad.pressed         = pressed_reg;
   assign pad.data_valid      = valid_reg;
   assign pad.busy            = (state_reg != IDLE);
endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed plus randomized reads of nes_pad_reader against a 4021-style pad model
// and a byte-level expectation model (buttons, previous result, latency arithmetic).
module tb_nes_pad_reader;
   localparam int LATCH_CYC = 6;
   localparam int HALF_CYC  = 3;
   localparam int EXP_LAT   = LATCH_CYC + 8*HALF_CYC + 7*HALF_CYC + 1;

   logic clk_25mhz = 1'b0;
   logic rst       = 1'b0;

   nes_pad_reader_if bus ();

   nes_pad_reader #(.LATCH_CYC(LATCH_CYC), .HALF_CYC(HALF_CYC)) dut (
      .clk_25mhz (clk_25mhz),
      .rst       (rst),
      .pad       (bus)
   );

   always #5 clk_25mhz = ~clk_25mhz;

   // Pad model: latch loads A onto the line, every clk_out rise advances one button.
   logic       pad_mode  = 1'b0;
   logic       pad_level = 1'b1;
   logic [7:0] pad_buttons = 8'h00;
   logic [3:0] pad_bit = 4'd0;

   always @(posedge bus.latch_out or posedge bus.clk_out) begin
      if (bus.latch_out)      pad_bit <= 4'd0;
      else if (pad_bit < 4'd8) pad_bit <= pad_bit + 4'd1;
   end

   assign bus.data_in = pad_mode ? pad_level
                      : ((pad_bit < 4'd8) ? ~pad_buttons[pad_bit[2:0]] : 1'b0);

   int tests = 0;
   int fails = 0;
   int latch_pulses = 0, clk_rises = 0, valid_count = 0;
   int latch_run = 0, clk_run = 0;
   logic [7:0] model_prev = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, sample 1 time unit later, run the per-cycle invariants.
   task automatic tick();
      @(posedge clk_25mhz);
      #1;
      check("latch_clk_exclusive", 32'(bus.latch_out & bus.clk_out), 0);
      check("clk_low_when_idle", 32'(!bus.busy & bus.clk_out), 0);
      if (bus.data_valid) valid_count++;
      if (!rst) begin
         latch_run = 0;
         clk_run   = 0;
      end else begin
         if (bus.latch_out) begin
            latch_run++;
            if (latch_run == 1) latch_pulses++;
         end else if (latch_run != 0) begin
            check("latch_width", latch_run, LATCH_CYC);
            latch_run = 0;
         end
         if (bus.clk_out) begin
            clk_run++;
            if (clk_run == 1) clk_rises++;
         end else if (clk_run != 0) begin
            check("clk_high_width", clk_run, HALF_CYC);
            clk_run = 0;
         end
      end
   endtask

   task automatic expect_result(input logic [7:0] data, output logic [7:0] exp_d,
                                output logic [7:0] exp_p);
      exp_d = data;
      exp_p = data & ~model_prev;
      model_prev = data;
   endtask

   // Full read starting with poll in the current cycle; ends in the cycle after DONE.
   task automatic do_read(input string tag, input logic [7:0] exp_d,
                          input logic [7:0] exp_p, input bit repoll);
      int lp0, cr0, vc0, n;
      lp0 = latch_pulses; cr0 = clk_rises; vc0 = valid_count;
      bus.poll = 1'b1;
      tick();
      bus.poll = 1'b0;
      n = 1;
      check({tag, "_busy_start"}, 32'(bus.busy), 1);
      while (!bus.data_valid && n < 200) begin
         bus.poll = repoll && (n == 10 || n == 51);
         tick();
         n++;
      end
      bus.poll = 1'b0;
      check({tag, "_latency"}, n, EXP_LAT);
      check({tag, "_data"}, 32'(bus.controller_data), 32'(exp_d));
      check({tag, "_pressed"}, 32'(bus.pressed), 32'(exp_p));
      check({tag, "_busy_done"}, 32'(bus.busy), 1);
      tick();
      check({tag, "_busy_after"}, 32'(bus.busy), 0);
      check({tag, "_valid_after"}, 32'(bus.data_valid), 0);
      if (repoll) begin
         for (int i = 0; i < 4; i++) tick();
         check({tag, "_no_requeue"}, 32'(bus.busy), 0);
      end
      check({tag, "_hold_data"}, 32'(bus.controller_data), 32'(exp_d));
      check({tag, "_latch_pulses"}, latch_pulses - lp0, 1);
      check({tag, "_clk_pulses"}, clk_rises - cr0, 7);
      check({tag, "_valid_pulses"}, valid_count - vc0, 1);
      $display("[TB] %s data=%02h pressed=%02h latency=%0d", tag,
               bus.controller_data, bus.pressed, n);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ed, ep, btn;
      int vc0;
      bus.poll = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("rst_latch", 32'(bus.latch_out), 0);
      check("rst_clk", 32'(bus.clk_out), 0);
      check("rst_data", 32'(bus.controller_data), 0);
      check("rst_pressed", 32'(bus.pressed), 0);
      check("rst_valid", 32'(bus.data_valid), 0);
      check("rst_busy", 32'(bus.busy), 0);

      // Reset release and poll land on the same edge.
      rst = 1'b1;
      pad_mode = 1'b0; pad_buttons = 8'h09;
      expect_result(8'h09, ed, ep);
      do_read("read_a_start", ed, ep, 1'b0);

      pad_buttons = 8'h88;
      expect_result(8'h88, ed, ep);
      do_read("read_start_right", ed, ep, 1'b0);

      pad_buttons = 8'h09;
      expect_result(8'h09, ed, ep);
      do_read("read_repoll", ed, ep, 1'b1);

      // Abort a read mid-way with reset.
      pad_buttons = 8'hF0;
      vc0 = valid_count;
      bus.poll = 1'b1;
      tick();
      bus.poll = 1'b0;
      for (int n = 1; n < 30; n++) tick();
      rst = 1'b0;
      #1;
      check("abort_latch", 32'(bus.latch_out), 0);
      check("abort_clk", 32'(bus.clk_out), 0);
      check("abort_data", 32'(bus.controller_data), 0);
      check("abort_pressed", 32'(bus.pressed), 0);
      check("abort_busy", 32'(bus.busy), 0);
      for (int i = 0; i < 3; i++) tick();
      rst = 1'b1;
      model_prev = 8'h00;
      for (int i = 0; i < 2; i++) tick();
      check("abort_no_valid", valid_count - vc0, 0);
      $display("[TB] reset_abort data=%02h busy=%0d", bus.controller_data, bus.busy);

      pad_buttons = 8'h09;
      expect_result(8'h09, ed, ep);
      do_read("read_after_abort", ed, ep, 1'b0);

      pad_mode = 1'b1; pad_level = 1'b1;
      expect_result(8'h00, ed, ep);
      do_read("no_pad_high", ed, ep, 1'b0);

      pad_level = 1'b0;
      expect_result(8'hFF, ed, ep);
      do_read("line_held_low", ed, ep, 1'b0);

      for (int r = 0; r < 12; r++) begin
         btn = 8'($urandom);
         pad_mode = ($urandom_range(0, 3) == 0);
         pad_level = 1'($urandom_range(0, 1));
         pad_buttons = btn;
         if (pad_mode) expect_result(pad_level ? 8'h00 : 8'hFF, ed, ep);
         else          expect_result(btn, ed, ep);
         do_read($sformatf("rand_%0d", r), ed, ep, 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
